// File: rtl/regfile_test_loader.sv
// Preloads the processor register file through its test port while holding the
// processor in reset; optional clear of r1..r31 and per-entry read-back verify.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | processor held in reset, regfile port released, waiting for start
// S_CLEAR | writing zero to r1..r31, one register per cycle
// S_LOAD  | accepting stream entries, each written on its accepting edge
// S_CHECK | reading back the last written register and comparing
// S_DONE  | processor released, load finished until next start or reset
module regfile_test_loader #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ERR_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_en,
    input  logic              verify_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              test,
    output logic              proc_reset,
    output logic              t_ctrl_writeEnable,
    output logic [REG_W-1:0]  t_ctrl_writeReg,
    output logic [DATA_W-1:0] t_data_writeReg,
    output logic [REG_W-1:0]  t_ctrl_readRegA,
    input  logic [DATA_W-1:0] t_data_readRegA,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [REG_W-1:0]  err_reg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [REG_W-1:0]    cnt_q, cnt_d;
    logic                ver_en_q, ver_en_d;
    logic [REG_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [REG_W-1:0]    err_reg_q, err_reg_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ver_en_q    <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            err_count_q <= '0;
            err_reg_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ver_en_q    <= ver_en_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            last_q      <= last_d;
            err_count_q <= err_count_d;
            err_reg_q   <= err_reg_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        ver_en_d           = ver_en_q;
        idx_d              = idx_q;
        data_d             = data_q;
        last_d             = last_q;
        err_count_d        = err_count_q;
        err_reg_d          = err_reg_q;
        t_ctrl_writeEnable = 1'b0;
        t_ctrl_writeReg    = '0;
        t_data_writeReg    = '0;
        t_ctrl_readRegA    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ver_en_d    = verify_en;
                    err_count_d = '0;
                    err_reg_d   = '0;
                    cnt_d       = REG_W'(1);
                    state_d     = clear_en ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                t_ctrl_writeEnable = 1'b1;
                t_ctrl_writeReg    = cnt_q;
                if (cnt_q == '1) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + REG_W'(1);
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    idx_d  = in_reg;
                    data_d = in_data;
                    last_d = in_last;
                    // r0 is hardwired zero: consume the entry without writing it
                    if (in_reg != '0) begin
                        t_ctrl_writeEnable = 1'b1;
                        t_ctrl_writeReg    = in_reg;
                        t_data_writeReg    = in_data;
                    end
                    if (ver_en_q && (in_reg != '0)) begin
                        state_d = S_CHECK;
                    end else if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CHECK: begin
                t_ctrl_readRegA = idx_q;
                if (t_data_readRegA != data_q) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (err_count_q == '0) begin
                        err_reg_d = idx_q;
                    end
                end
                state_d = last_q ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign test       = busy;
    assign proc_reset = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign in_ready   = (state_q == S_LOAD);
    assign err_count  = err_count_q;
    assign err_reg    = err_reg_q;

endmodule

// File: tb/tb_regfile_test_loader.sv
// Directed bench for regfile_test_loader with a small behavioural register file
// attached to the test port.
module tb_regfile_test_loader;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ERR_W  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              clear_en = 1'b0;
    logic              verify_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_W-1:0]  in_reg = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              test;
    logic              proc_reset;
    logic              t_ctrl_writeEnable;
    logic [REG_W-1:0]  t_ctrl_writeReg;
    logic [DATA_W-1:0] t_data_writeReg;
    logic [REG_W-1:0]  t_ctrl_readRegA;
    logic [DATA_W-1:0] t_data_readRegA;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_count;
    logic [REG_W-1:0]  err_reg;

    regfile_test_loader #(.DATA_W(DATA_W), .REG_W(REG_W), .ERR_W(ERR_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .clear_en           (clear_en),
        .verify_en          (verify_en),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_reg             (in_reg),
        .in_data            (in_data),
        .in_last            (in_last),
        .test               (test),
        .proc_reset         (proc_reset),
        .t_ctrl_writeEnable (t_ctrl_writeEnable),
        .t_ctrl_writeReg    (t_ctrl_writeReg),
        .t_data_writeReg    (t_data_writeReg),
        .t_ctrl_readRegA    (t_ctrl_readRegA),
        .t_data_readRegA    (t_data_readRegA),
        .busy               (busy),
        .done               (done),
        .err_count          (err_count),
        .err_reg            (err_reg)
    );

    always #5 clock = ~clock;

    // Register file model: r0 reads zero, optional fault drops writes to r6,
    // backdoor port lets the bench preload values while the loader is idle.
    logic [DATA_W-1:0] rf [32] = '{default: '0};
    logic              drop_r6 = 1'b0;
    logic              bd_we = 1'b0;
    logic [REG_W-1:0]  bd_idx = '0;
    logic [DATA_W-1:0] bd_data = '0;
    int                wcnt = 0;

    always @(posedge clock) begin
        if (test && t_ctrl_writeEnable) begin
            wcnt <= wcnt + 1;
            if (t_ctrl_writeReg != '0 && !(drop_r6 && t_ctrl_writeReg == 5'd6))
                rf[t_ctrl_writeReg] <= t_data_writeReg;
        end else if (bd_we && bd_idx != '0) begin
            rf[bd_idx] <= bd_data;
        end
    end

    assign t_data_readRegA = (t_ctrl_readRegA == '0) ? '0 : rf[t_ctrl_readRegA];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic clr, input logic ver);
        start = 1'b1; clear_en = clr; verify_en = ver;
        tick();
        start = 1'b0; clear_en = 1'b0; verify_en = 1'b0;
    endtask

    task automatic backdoor(input logic [REG_W-1:0] idx, input logic [DATA_W-1:0] val);
        bd_we = 1'b1; bd_idx = idx; bd_data = val;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic put(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d, input logic l);
        in_valid = 1'b1; in_reg = r; in_data = d; in_last = l;
    endtask

    initial begin
        int w0;
        int busy_cnt;
        logic [3:0] rdy_pat;
        logic found;

        // Reset
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_proc_reset", proc_reset, 1);
        chk("rst_test", test, 0);
        chk("rst_busy_done_ready", {busy, done, in_ready, t_ctrl_writeEnable}, 4'b0000);
        chk("rst_err", {err_count, err_reg}, 0);

        // Basic load, no clear, no verify
        w0 = wcnt;
        pulse_start(1'b0, 1'b0);
        chk("t1_session", {test, proc_reset, busy, in_ready}, 4'b1111);
        put(5'd1, 32'd65535, 1'b0); #1;
        chk("t1_we1", {t_ctrl_writeEnable, t_ctrl_writeReg}, {1'b1, 5'd1});
        tick();
        put(5'd2, 32'd7, 1'b0); #1;
        chk("t1_we2", {t_ctrl_writeEnable, t_ctrl_writeReg}, {1'b1, 5'd2});
        tick();
        put(5'd31, 32'hDEADBEEF, 1'b1); #1;
        chk("t1_we3", {t_ctrl_writeEnable, t_ctrl_writeReg, t_data_writeReg}, {1'b1, 5'd31, 32'hDEADBEEF});
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t1_done", {done, proc_reset, test, busy}, 4'b1000);
        chk("t1_wcnt", wcnt - w0, 3);
        chk("t1_r1", rf[1], 32'd65535);
        chk("t1_r2", rf[2], 32'd7);
        chk("t1_r31", rf[31], 32'hDEADBEEF);

        // Clear then load
        backdoor(5'd5, 32'd123);
        chk("t2_preload", rf[5], 32'd123);
        w0 = wcnt;
        pulse_start(1'b1, 1'b0);
        chk("t2_first_clear", {t_ctrl_writeEnable, t_ctrl_writeReg, t_data_writeReg}, {1'b1, 5'd1, 32'd0});
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (busy) busy_cnt++;
            in_valid = in_ready; in_reg = 5'd3; in_data = 32'd9; in_last = 1'b1;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_busy_len", busy_cnt, 32);
        chk("t2_wcnt", wcnt - w0, 32);
        chk("t2_r5", rf[5], 0);
        chk("t2_r1", rf[1], 0);
        chk("t2_r31", rf[31], 0);
        chk("t2_r3", rf[3], 32'd9);

        // Verify pass
        pulse_start(1'b0, 1'b1);
        put(5'd4, 32'd100, 1'b0);
        rdy_pat[3] = in_ready;
        tick();
        put(5'd6, 32'd200, 1'b1);
        rdy_pat[2] = in_ready;
        chk("t3_check_readA", t_ctrl_readRegA, 5'd4);
        tick();
        rdy_pat[1] = in_ready;
        tick();
        rdy_pat[0] = in_ready;
        in_valid = 1'b0; in_last = 1'b0;
        chk("t3_ready_pattern", rdy_pat, 4'b1010);
        tick();
        chk("t3_done_err", {done, err_count}, {1'b1, 8'd0});

        // Verify fail: writes to r6 dropped
        drop_r6 = 1'b1;
        backdoor(5'd6, 32'd1);
        pulse_start(1'b0, 1'b1);
        chk("t4_err_cleared", err_count, 0);
        put(5'd4, 32'd100, 1'b0);
        tick();
        put(5'd6, 32'd200, 1'b1);
        tick(); tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        drop_r6 = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_err_count", err_count, 8'd1);
        chk("t4_err_reg", err_reg, 5'd6);

        // r0 entry and idle gaps
        w0 = wcnt;
        pulse_start(1'b0, 1'b0);
        chk("t5_err_cleared", {err_count, err_reg}, 0);
        put(5'd0, 32'd55, 1'b0); #1;
        chk("t5_r0_no_we", t_ctrl_writeEnable, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_gap_no_we", {t_ctrl_writeEnable, in_ready}, 2'b01);
            tick();
        end
        put(5'd7, 32'd1, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_wcnt", wcnt - w0, 1);
        chk("t5_r0", rf[0], 0);
        chk("t5_r7", rf[7], 32'd1);

        // Reset in the middle of CLEAR
        backdoor(5'd11, 32'd11);
        backdoor(5'd31, 32'd31);
        pulse_start(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (t_ctrl_writeEnable && t_ctrl_writeReg == 5'd10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_reached_cnt10", found, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        w0 = wcnt;
        chk("t6_idle", {proc_reset, busy, test, done, t_ctrl_writeEnable}, 5'b10000);
        tick(); tick(); tick();
        chk("t6_no_writes", wcnt - w0, 0);
        chk("t6_r10", rf[10], 0);
        chk("t6_r11", rf[11], 32'd11);
        chk("t6_r31", rf[31], 32'd31);
        chk("t6_still_idle", {proc_reset, busy, done}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
